riscv_dual_issue: RTL and testbench

- Issue stage of the dual-issue core; sits between fetch and the two decoders.
- Takes a two-instruction fetch bundle and steers the older instruction to pipe 1 (full-capability) and the younger to pipe 2 (ALU-only) when the pair is legal to co-issue.
- Otherwise it holds the younger instruction in a one-entry skid register and issues it alone on pipe 1 the next cycle.
- Outputs are registered and form the issue/decode pipeline register.

---
 rtl/riscv_dual_issue_pkg.sv | 44 ++++
 rtl/riscv_pair_check.sv | 38 +++
 rtl/riscv_dual_issue.sv | 127 ++++++++++++
 tb/tb_riscv_dual_issue.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dual_issue_pkg.sv
// Shared types for the dual-issue issue stage: opcodes, ABI register names,
// issue FSM states and the issue-slot record.
package riscv_dual_issue_pkg;

  typedef enum logic [6:0] {
    OP_LOAD     = 7'b0000011,
    OP_MISC_MEM = 7'b0001111,
    OP_IMM      = 7'b0010011,
    OP_AUIPC    = 7'b0010111,
    OP_STORE    = 7'b0100011,
    OP_OP       = 7'b0110011,
    OP_LUI      = 7'b0110111,
    OP_BRANCH   = 7'b1100011,
    OP_JALR     = 7'b1100111,
    OP_JAL      = 7'b1101111,
    OP_SYSTEM   = 7'b1110011
  } opcode_t;

  typedef enum logic [4:0] {
    ZERO, RA, SP, GP, TP, T0, T1, T2, S0, S1,
    A0, A1, A2, A3, A4, A5, A6, A7,
    S2, S3, S4, S5, S6, S7, S8, S9, S10, S11,
    T3, T4, T5, T6
  } abi_reg_t;

  typedef enum logic {ISSUE_NORMAL, ISSUE_SPLIT} issue_state_t;

  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } issue_slot_t;

  function automatic logic is_defined_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_OP,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_pair_check.sv
// Combinational co-issue legality check for an older/younger instruction pair:
// opcode capability plus RAW/WAW register hazards.
module riscv_pair_check
  import riscv_dual_issue_pkg::*;
(
  input  logic [31:0] inst0,
  input  logic [31:0] inst1,
  input  logic        inst1_valid,
  input  logic        dual_en,
  output logic        pairable
);

  opcode_t  op0, op1;
  abi_reg_t rd0, rd1, src1, src2;
  logic     older_ok, younger_ok, older_writes, reads_rs1, reads_rs2, raw, waw;

  assign op0  = opcode_t'(inst0[6:0]);
  assign op1  = opcode_t'(inst1[6:0]);
  assign rd0  = abi_reg_t'(inst0[11:7]);
  assign rd1  = abi_reg_t'(inst1[11:7]);
  assign src1 = abi_reg_t'(inst1[19:15]);
  assign src2 = abi_reg_t'(inst1[24:20]);

  always_comb begin
    older_ok     = is_defined_op(inst0[6:0]) &&
                   !(op0 inside {OP_JAL, OP_JALR, OP_BRANCH, OP_SYSTEM});
    younger_ok   = op1 inside {OP_OP, OP_IMM, OP_LUI, OP_AUIPC};
    older_writes = !(op0 inside {OP_STORE, OP_BRANCH}) && (rd0 != ZERO);
    // LUI/AUIPC read no registers; OP-IMM reads only rs1
    reads_rs1    = op1 inside {OP_OP, OP_IMM};
    reads_rs2    = (op1 == OP_OP);
    raw          = older_writes && ((reads_rs1 && (src1 == rd0)) ||
                                    (reads_rs2 && (src2 == rd0)));
    waw          = (rd0 != ZERO) && (rd1 == rd0);
    pairable     = dual_en && inst1_valid && younger_ok && older_ok && !raw && !waw;
  end

endmodule

// File: rtl/riscv_dual_issue.sv
// Dual-issue issue stage: steers a fetch bundle onto pipe 1 / pipe 2, splitting
// illegal pairs through a one-entry hold register. Optional RISCV_ISSUE_STATS_EN.
module riscv_dual_issue
  import riscv_dual_issue_pkg::*;
#(
  parameter bit          DUAL_EN  = 1'b1,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fb_valid,
  output logic        fb_ready,
  input  logic [31:0] fb_pc,
  input  logic [31:0] fb_inst0,
  input  logic [31:0] fb_inst1,
  input  logic        fb_inst1_valid,
  input  logic        stall_in,
  input  logic        flush,
  output logic        p1_valid,
  output logic [31:0] p1_inst,
  output logic [31:0] p1_pc,
  output logic        p2_valid,
  output logic [31:0] p2_inst,
  output logic [31:0] p2_pc
`ifdef RISCV_ISSUE_STATS_EN
  ,
  output logic [31:0] stat_dual_cnt,
  output logic [31:0] stat_split_cnt
`endif
);

  localparam issue_slot_t EMPTY_SLOT = '{valid: 1'b0, inst: NOP_INST, pc: 32'h0};

  issue_state_t state_reg, state_next;
  issue_slot_t  p1_reg, p1_next, p2_reg, p2_next, hold_reg, hold_next;
  logic         pairable;

  riscv_pair_check u_pair_check (
    .inst0       (fb_inst0),
    .inst1       (fb_inst1),
    .inst1_valid (fb_inst1_valid),
    .dual_en     (DUAL_EN),
    .pairable    (pairable)
  );

  assign fb_ready = (state_reg == ISSUE_NORMAL) && !stall_in && !flush;

  always_comb begin
    state_next = state_reg;
    p1_next    = p1_reg;
    p2_next    = p2_reg;
    hold_next  = hold_reg;
    if (flush) begin
      p1_next    = EMPTY_SLOT;
      p2_next    = EMPTY_SLOT;
      hold_next  = '0;
      state_next = ISSUE_NORMAL;
    end else if (!stall_in) begin
      case (state_reg)
        ISSUE_NORMAL: begin
          if (fb_valid) begin
            p1_next = '{valid: 1'b1, inst: fb_inst0, pc: fb_pc};
            if (pairable) begin
              p2_next = '{valid: 1'b1, inst: fb_inst1, pc: fb_pc + 32'd4};
            end else begin
              p2_next = EMPTY_SLOT;
              if (fb_inst1_valid) begin
                hold_next  = '{valid: 1'b1, inst: fb_inst1, pc: fb_pc + 32'd4};
                state_next = ISSUE_SPLIT;
              end
            end
          end else begin
            p1_next = EMPTY_SLOT;
            p2_next = EMPTY_SLOT;
          end
        end
        ISSUE_SPLIT: begin
          p1_next    = '{valid: 1'b1, inst: hold_reg.inst, pc: hold_reg.pc};
          p2_next    = EMPTY_SLOT;
          hold_next  = '0;
          state_next = ISSUE_NORMAL;
        end
        default: state_next = ISSUE_NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ISSUE_NORMAL;
      p1_reg    <= EMPTY_SLOT;
      p2_reg    <= EMPTY_SLOT;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      p1_reg    <= p1_next;
      p2_reg    <= p2_next;
      hold_reg  <= hold_next;
    end
  end

  assign p1_valid = p1_reg.valid;
  assign p1_inst  = p1_reg.inst;
  assign p1_pc    = p1_reg.pc;
  assign p2_valid = p2_reg.valid;
  assign p2_inst  = p2_reg.inst;
  assign p2_pc    = p2_reg.pc;

`ifdef RISCV_ISSUE_STATS_EN
  logic accept;
  assign accept = fb_ready && fb_valid;

  // Counters survive flush; only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_dual_cnt  <= '0;
      stat_split_cnt <= '0;
    end else begin
      if (accept && pairable)
        stat_dual_cnt <= stat_dual_cnt + 32'd1;
      if (accept && fb_inst1_valid && !pairable)
        stat_split_cnt <= stat_split_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_dual_issue.sv
// Scoreboard bench for riscv_dual_issue: directed bundles then random traffic
// against a queue-based reference model; also checks a DUAL_EN=0 instance.
module tb_riscv_dual_issue;

  localparam logic [6:0] K_LOAD = 7'b0000011, K_MISC = 7'b0001111, K_IMM = 7'b0010011,
                         K_AUIPC = 7'b0010111, K_STORE = 7'b0100011, K_OP = 7'b0110011,
                         K_LUI = 7'b0110111, K_BRANCH = 7'b1100011, K_JALR = 7'b1100111,
                         K_JAL = 7'b1101111, K_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, fb_valid, fb_inst1_valid, stall_in, flush;
  logic [31:0] fb_pc, fb_inst0, fb_inst1;
  logic        fb_ready, p1_valid, p2_valid;
  logic [31:0] p1_inst, p1_pc, p2_inst, p2_pc;
  logic        s_fb_ready, s_p1_valid, s_p2_valid;
  logic [31:0] s_p1_inst, s_p1_pc, s_p2_inst, s_p2_pc;
`ifdef RISCV_ISSUE_STATS_EN
  logic [31:0] stat_dual_cnt, stat_split_cnt, s_stat_dual_cnt, s_stat_split_cnt;
`endif

  always #5 clk = ~clk;

  riscv_dual_issue #(.DUAL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_pc(fb_pc),
    .fb_inst0(fb_inst0), .fb_inst1(fb_inst1), .fb_inst1_valid(fb_inst1_valid),
    .stall_in(stall_in), .flush(flush),
    .p1_valid(p1_valid), .p1_inst(p1_inst), .p1_pc(p1_pc),
    .p2_valid(p2_valid), .p2_inst(p2_inst), .p2_pc(p2_pc)
`ifdef RISCV_ISSUE_STATS_EN
    , .stat_dual_cnt(stat_dual_cnt), .stat_split_cnt(stat_split_cnt)
`endif
  );

  riscv_dual_issue #(.DUAL_EN(1'b0)) dut_single (
    .clk(clk), .rst(rst), .fb_valid(fb_valid), .fb_ready(s_fb_ready), .fb_pc(fb_pc),
    .fb_inst0(fb_inst0), .fb_inst1(fb_inst1), .fb_inst1_valid(fb_inst1_valid),
    .stall_in(stall_in), .flush(flush),
    .p1_valid(s_p1_valid), .p1_inst(s_p1_inst), .p1_pc(s_p1_pc),
    .p2_valid(s_p2_valid), .p2_inst(s_p2_inst), .p2_pc(s_p2_pc)
`ifdef RISCV_ISSUE_STATS_EN
    , .stat_dual_cnt(s_stat_dual_cnt), .stat_split_cnt(s_stat_split_cnt)
`endif
  );

  typedef struct {
    bit          v1;
    logic [31:0] i1;
    logic [31:0] pc1;
    bit          v2;
    logic [31:0] i2;
    logic [31:0] pc2;
  } exp_t;

  exp_t        exp_q[$];
  bit          rdy_q[$];
  int          checks = 0;
  int          failures = 0;
  exp_t        cur;
  bit          held_v;
  logic [31:0] held_i, held_pc;
  int          m_dual = 0;
  int          m_split = 0;

  function automatic exp_t empty_exp();
    exp_t e;
    e.v1 = 0; e.i1 = NOP; e.pc1 = 32'h0;
    e.v2 = 0; e.i2 = NOP; e.pc2 = 32'h0;
    return e;
  endfunction

  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), 3'b000, 5'(rd), K_IMM};
  endfunction

  function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), K_OP};
  endfunction

  // Reference pairing rule, phrased as "which registers does the younger read"
  function automatic bit model_pair(input logic [31:0] i0, input logic [31:0] i1, input bit i1v);
    logic [6:0] o0, o1;
    logic [4:0] d0, d1;
    logic [4:0] srcs[$];
    o0 = i0[6:0]; o1 = i1[6:0]; d0 = i0[11:7]; d1 = i1[11:7];
    if (!i1v) return 0;
    if (!(o1 inside {K_OP, K_IMM, K_LUI, K_AUIPC})) return 0;
    if (!(o0 inside {K_LOAD, K_STORE, K_IMM, K_OP, K_LUI, K_AUIPC, K_MISC})) return 0;
    if (o1 == K_OP || o1 == K_IMM) srcs.push_back(i1[19:15]);
    if (o1 == K_OP) srcs.push_back(i1[24:20]);
    if (d0 != 5'd0 && o0 != K_STORE)
      foreach (srcs[k]) if (srcs[k] == d0) return 0;
    if (d0 != 5'd0 && d1 == d0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  op;
    case ($urandom_range(0, 11))
      0: op = K_LOAD;   1: op = K_STORE;  2: op = K_IMM;  3: op = K_OP;
      4: op = K_LUI;    5: op = K_AUIPC;  6: op = K_BRANCH; 7: op = K_JAL;
      8: op = K_JALR;   9: op = K_SYSTEM; 10: op = K_MISC; default: op = 7'b1111111;
    endcase
    r = $urandom();
    r[6:0]   = op;
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] i0,
                      input logic [31:0] i1, input bit i1v, input bit st, input bit fl);
    exp_t nxt;
    @(negedge clk);
    rst = 0; fb_valid = v; fb_pc = pc; fb_inst0 = i0; fb_inst1 = i1;
    fb_inst1_valid = i1v; stall_in = st; flush = fl;
    #1;
    rdy_q.push_back(!held_v && !st && !fl);
    nxt = cur;
    if (fl) begin
      nxt = empty_exp();
      held_v = 0;
    end else if (!st) begin
      nxt = empty_exp();
      if (held_v) begin
        nxt.v1 = 1; nxt.i1 = held_i; nxt.pc1 = held_pc;
        held_v = 0;
      end else if (v) begin
        nxt.v1 = 1; nxt.i1 = i0; nxt.pc1 = pc;
        if (model_pair(i0, i1, i1v)) begin
          nxt.v2 = 1; nxt.i2 = i1; nxt.pc2 = pc + 32'd4;
          m_dual++;
        end else if (i1v) begin
          held_v = 1; held_i = i1; held_pc = pc + 32'd4;
          m_split++;
        end
      end
    end
    cur = nxt;
    exp_q.push_back(nxt);
  endtask

  // Output monitor: one pop and one printed line per issue-register transaction
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (p1_valid !== e.v1 || p1_inst !== e.i1 || p1_pc !== e.pc1) begin
        failures++;
        $display("FAIL p1 got=%0b/%h/%h want=%0b/%h/%h", p1_valid, p1_inst, p1_pc, e.v1, e.i1, e.pc1);
      end
      checks++;
      if (p2_valid !== e.v2 || p2_inst !== e.i2 || p2_pc !== e.pc2) begin
        failures++;
        $display("FAIL p2 got=%0b/%h/%h want=%0b/%h/%h", p2_valid, p2_inst, p2_pc, e.v2, e.i2, e.pc2);
      end
      $display("txn t=%0t p1=%0b/%h/%h p2=%0b/%h/%h", $time, p1_valid, p1_inst, p1_pc,
               p2_valid, p2_inst, p2_pc);
    end
    checks++;
    if (s_p2_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_p2_valid got=%0b want=0", s_p2_valid);
    end
  end

  always @(negedge clk) begin
    bit r;
    #2;
    if (rdy_q.size() > 0) begin
      r = rdy_q.pop_front();
      checks++;
      if (fb_ready !== r) begin
        failures++;
        $display("FAIL fb_ready got=%0b want=%0b", fb_ready, r);
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    rst = 1; fb_valid = 0; fb_pc = 0; fb_inst0 = 0; fb_inst1 = 0;
    fb_inst1_valid = 0; stall_in = 0; flush = 0;
    held_v = 0; held_i = 0; held_pc = 0; cur = empty_exp();
    repeat (3) begin
      @(negedge clk);
      #1;
      exp_q.push_back(empty_exp());
    end

    // Legal pair, then RAW split with a bundle offered while busy
    step(1, 32'h100, enc_addi(1, 0, 5), enc_add(2, 3, 4), 1, 0, 0);
    step(1, 32'h200, enc_addi(1, 0, 5), enc_add(2, 1, 4), 1, 0, 0);
    step(1, 32'h300, enc_addi(7, 0, 1), enc_add(8, 0, 0), 1, 0, 0);
    step(0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    // Branch older forces split; flush in the split cycle kills the held younger
    step(1, 32'h400, 32'h0000_0463, enc_addi(5, 0, 1), 1, 0, 0);
    step(1, 32'h500, enc_addi(1, 0, 1), enc_add(2, 3, 4), 1, 0, 1);
    step(0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    // Store younger splits; rd=x0 pair is legal
    step(1, 32'h600, 32'h0001_2303, 32'h0061_2223, 1, 0, 0);
    step(0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step(1, 32'h700, enc_addi(0, 0, 1), enc_addi(0, 0, 2), 1, 0, 0);
    // Stall holds outputs; stall with flush flushes
    step(1, 32'h800, enc_addi(1, 0, 5), enc_add(2, 3, 4), 1, 0, 0);
    repeat (3) step(1, 32'h900, enc_addi(3, 0, 5), enc_add(4, 3, 4), 1, 1, 0);
    step(1, 32'h900, enc_addi(3, 0, 5), enc_add(4, 3, 4), 1, 1, 1);
    // PC wrap and a single-valid bundle
    step(1, 32'hFFFF_FFFC, enc_addi(9, 0, 1), enc_add(10, 3, 4), 1, 0, 0);
    step(1, 32'h40, enc_addi(9, 0, 1), enc_add(10, 3, 4), 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      rpc = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) rpc = 32'hFFFF_FFFC;
      step($urandom_range(0, 9) < 8, rpc, rand_inst(), rand_inst(),
           $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
    end
    step(0, 32'h0, 32'h0, 32'h0, 0, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || rdy_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d/%0d pending want=0", exp_q.size(), rdy_q.size());
    end
`ifdef RISCV_ISSUE_STATS_EN
    checks++;
    if (stat_dual_cnt !== 32'(m_dual)) begin
      failures++;
      $display("FAIL stat_dual_cnt got=%0d want=%0d", stat_dual_cnt, m_dual);
    end
    checks++;
    if (stat_split_cnt !== 32'(m_split)) begin
      failures++;
      $display("FAIL stat_split_cnt got=%0d want=%0d", stat_split_cnt, m_split);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
